// File: rtl/snn_input_sequencer.sv
// -----------------------------------------------------------------------------
// snn_input_sequencer
//
// Upstream feeder for the SNN core. Gathers one task (KER_N kernel bytes,
// WGT_N weight bytes, IMG_N image bytes) from a byte-wide valid/ready host
// stream into a local buffer. It then replays the task as one contiguous
// IMG_N-cycle in_valid burst, waits for the core's single-cycle result and
// reports it, or a timeout, back to the host. Only one task is in flight.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   s_valid        host byte valid
//   s_data[7:0]    host byte; per task: ker[0..], wgt[0..], img[0..]
//   s_ready        byte accepted on s_valid & s_ready (registered)
//   snn_in_valid   burst strobe to core (registered)
//   snn_img/ker/weight[7:0]  burst data to core, zero outside the burst
//   snn_out_valid  core result strobe (honoured only while waiting)
//   snn_out_data[9:0]  core result
//   res_valid      one-cycle result pulse to host
//   res_data[9:0]  captured result, held until the next res_valid
//   res_err        qualifies res_valid: 1 = timeout (res_data = 0)
// -----------------------------------------------------------------------------
module snn_input_sequencer #(
    parameter int KER_N   = 9,
    parameter int WGT_N   = 4,
    parameter int IMG_N   = 72,
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    output logic       snn_in_valid,
    output logic [7:0] snn_img,
    output logic [7:0] snn_ker,
    output logic [7:0] snn_weight,
    input  logic       snn_out_valid,
    input  logic [9:0] snn_out_data,
    output logic       res_valid,
    output logic [9:0] res_data,
    output logic       res_err
);

    localparam int TOTAL = KER_N + WGT_N + IMG_N;
    localparam int IDX_W = $clog2(TOTAL);
    localparam int K_W   = $clog2(IMG_N);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TOTAL - 1);
    localparam logic [IDX_W-1:0] IMG_BASE  = IDX_W'(KER_N + WGT_N);
    localparam logic [IDX_W-1:0] WGT_BASE  = IDX_W'(KER_N);
    localparam logic [K_W-1:0]   LAST_K    = K_W'(IMG_N - 1);
    localparam logic [K_W-1:0]   KER_LIM   = K_W'(KER_N);
    localparam logic [K_W-1:0]   WGT_LIM   = K_W'(WGT_N);
    localparam logic [7:0]       TIMER_END = 8'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_WAIT   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [7:0]       timer_q, timer_d;
    logic             s_ready_q, s_ready_d;
    logic             in_valid_q, in_valid_d;
    logic [7:0]       img_q, img_d;
    logic [7:0]       ker_q, ker_d;
    logic [7:0]       wgt_q, wgt_d;
    logic             res_valid_q, res_valid_d;
    logic [9:0]       res_data_q, res_data_d;
    logic             res_err_q, res_err_d;

    logic [7:0]       buf_mem [TOTAL];

    // Burst-slot selection: when drive_en is set, the outputs present stream
    // cycle drive_k on the next edge.
    logic             drive_en;
    logic [K_W-1:0]   drive_k;
    logic             accept;

    // s_ready_q is only ever high in LOAD, so it alone qualifies the handshake.
    assign accept = s_valid & s_ready_q;

    // NOTE: the task buffer is plain storage with no reset; every byte is
    // rewritten before the burst reads it, so resetting it would only cost logic.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_mem[idx_q] <= s_data;
        end
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        k_d         = k_q;
        timer_d     = timer_q;
        s_ready_d   = 1'b0;
        in_valid_d  = 1'b0;
        img_d       = 8'd0;
        ker_d       = 8'd0;
        wgt_d       = 8'd0;
        res_valid_d = 1'b0;
        res_err_d   = 1'b0;
        res_data_d  = res_data_q;
        drive_en    = 1'b0;
        drive_k     = '0;

        case (state_q)
            S_IDLE: begin
                state_d = S_LOAD;
                idx_d   = '0;
            end
            S_LOAD: begin
                s_ready_d = 1'b1;
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        // Zero bubble: slot 0 goes out on the edge that takes
                        // the last byte; it only needs bytes already stored.
                        s_ready_d = 1'b0;
                        state_d   = S_STREAM;
                        k_d       = '0;
                        drive_en  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_STREAM: begin
                if (k_q == LAST_K) begin
                    state_d = S_WAIT;
                    timer_d = 8'd0;
                end else begin
                    k_d      = k_q + 1'b1;
                    drive_en = 1'b1;
                    drive_k  = k_q + 1'b1;
                end
            end
            default: begin // S_WAIT
                // The strobe is tested first so it wins over a same-cycle timeout.
                if (snn_out_valid) begin
                    res_valid_d = 1'b1;
                    res_data_d  = snn_out_data;
                    state_d     = S_LOAD;
                    idx_d       = '0;
                end else if (timer_q == TIMER_END) begin
                    res_valid_d = 1'b1;
                    res_err_d   = 1'b1;
                    res_data_d  = 10'd0;
                    state_d     = S_LOAD;
                    idx_d       = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
        endcase

        if (drive_en) begin
            in_valid_d = 1'b1;
            img_d      = buf_mem[IMG_BASE + IDX_W'(drive_k)];
            if (drive_k < KER_LIM) ker_d = buf_mem[IDX_W'(drive_k)];
            if (drive_k < WGT_LIM) wgt_d = buf_mem[WGT_BASE + IDX_W'(drive_k)];
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            k_q         <= '0;
            timer_q     <= 8'd0;
            s_ready_q   <= 1'b0;
            in_valid_q  <= 1'b0;
            img_q       <= 8'd0;
            ker_q       <= 8'd0;
            wgt_q       <= 8'd0;
            res_valid_q <= 1'b0;
            res_data_q  <= 10'd0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            k_q         <= k_d;
            timer_q     <= timer_d;
            s_ready_q   <= s_ready_d;
            in_valid_q  <= in_valid_d;
            img_q       <= img_d;
            ker_q       <= ker_d;
            wgt_q       <= wgt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
        end
    end

    assign s_ready      = s_ready_q;
    assign snn_in_valid = in_valid_q;
    assign snn_img      = img_q;
    assign snn_ker      = ker_q;
    assign snn_weight   = wgt_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign res_err      = res_err_q;

endmodule

// File: tb/tb_snn_input_sequencer.sv
// -----------------------------------------------------------------------------
// tb_snn_input_sequencer
//
// Self-checking bench for snn_input_sequencer. Tasks are loaded through the
// host stream (with and without random gaps). The burst is compared against
// a task-level model: slot k carries img[k], ker[k] for k<9 and wgt[k] for
// k<4, zero otherwise. The result phase is checked against the expected
// strobe/timeout outcome.
// -----------------------------------------------------------------------------
module tb_snn_input_sequencer;

    localparam int NBYTES = 85;
    localparam int NIMG   = 72;
    localparam int TMO    = 64;

    logic       clk;
    logic       rst_n;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       snn_in_valid;
    logic [7:0] snn_img;
    logic [7:0] snn_ker;
    logic [7:0] snn_weight;
    logic       snn_out_valid;
    logic [9:0] snn_out_data;
    logic       res_valid;
    logic [9:0] res_data;
    logic       res_err;

    int checks   = 0;
    int failures = 0;

    logic [7:0] task_bytes [NBYTES];

    snn_input_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .snn_in_valid  (snn_in_valid),
        .snn_img       (snn_img),
        .snn_ker       (snn_ker),
        .snn_weight    (snn_weight),
        .snn_out_valid (snn_out_valid),
        .snn_out_data  (snn_out_data),
        .res_valid     (res_valid),
        .res_data      (res_data),
        .res_err       (res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Task-level model of burst slot k: {in_valid, img, ker, weight}.
    function automatic logic [31:0] slot_model(input int k);
        logic [7:0] img, ker, wgt;
        img = task_bytes[13 + k];
        ker = (k < 9) ? task_bytes[k] : 8'd0;
        wgt = (k < 4) ? task_bytes[9 + k] : 8'd0;
        return {7'd0, 1'b1, img, ker, wgt};
    endfunction

    task automatic fill_directed();
        for (int i = 0; i < NBYTES; i++)
            task_bytes[i] = (i < 13) ? 8'(i + 1) : 8'(i - 12);
    endtask

    task automatic fill_random();
        for (int i = 0; i < NBYTES; i++)
            task_bytes[i] = 8'($urandom_range(255));
    endtask

    // Offers the task bytes; gap_pct is the chance of idling a cycle.
    // Returns right after the edge carrying the last handshake.
    task automatic send_task(input int gap_pct);
        int i = 0;
        int budget = 0;
        while (i < NBYTES && budget < 2000) begin
            @(negedge clk);
            s_valid = ($urandom_range(99) >= gap_pct);
            s_data  = task_bytes[i];
            if (s_valid && s_ready) i++;
            budget++;
        end
        check("load_budget", i, NBYTES);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    // Checks the burst slot by slot; abort_at >= 0 resets mid-burst there.
    task automatic check_burst(input int abort_at);
        for (int k = 0; k < NIMG; k++) begin
            @(negedge clk);
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("reset_drops_valid", {snn_in_valid, snn_img, snn_ker, snn_weight}, 0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            check($sformatf("burst_k%0d", k), {7'd0, snn_in_valid, snn_img, snn_ker, snn_weight},
                  slot_model(k));
            if (k == 0) check("s_ready_low_in_burst", s_ready, 0);
            // A strobe during the burst must be ignored.
            snn_out_valid = (k == 5);
            snn_out_data  = 10'h155;
        end
        @(negedge clk);
        snn_out_valid = 1'b0;
        check("burst_end", {snn_in_valid, snn_img, snn_ker, snn_weight, res_valid}, 0);
    endtask

    // Called at the negedge of WAIT cycle 0. strobe_at < 0 means no strobe.
    task automatic wait_result(input int strobe_at, input logic [9:0] data);
        int  last_c;
        logic exp_err;
        exp_err = !(strobe_at >= 0 && strobe_at < TMO);
        last_c  = exp_err ? TMO - 1 : strobe_at;
        for (int c = 0; c <= last_c; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 0 || c == last_c) check($sformatf("wait_quiet_c%0d", c), res_valid, 0);
            snn_out_valid = (c == strobe_at);
            snn_out_data  = data;
        end
        @(negedge clk);
        snn_out_valid = 1'b0;
        check("res_valid_pulse", res_valid, 1);
        check("res_err", res_err, {31'd0, exp_err});
        check("res_data", res_data, exp_err ? 32'd0 : {22'd0, data});
        @(negedge clk);
        check("res_pulse_single", {res_valid, res_err}, 0);
        check("res_data_held", res_data, exp_err ? 32'd0 : {22'd0, data});
        check("s_ready_after_res", s_ready, 1);
    endtask

    initial begin
        logic any_res;
        logic [9:0] rdata;

        rst_n         = 1'b0;
        s_valid       = 1'b0;
        s_data        = 8'd0;
        snn_out_valid = 1'b0;
        snn_out_data  = 10'd0;

        repeat (3) @(negedge clk);
        check("reset_outputs", {s_ready, snn_in_valid, snn_img, snn_ker, snn_weight,
                                res_valid, res_err}, 0);
        check("reset_res_data", res_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("s_ready_edge1", s_ready, 0);
        @(negedge clk);
        check("s_ready_edge2", s_ready, 1);
        repeat (4) begin
            @(negedge clk);
            check("idle_quiet", {snn_in_valid, res_valid}, 0);
        end

        // Directed task, no gaps, result strobe 10 cycles into WAIT.
        fill_directed();
        send_task(0);
        check_burst(-1);
        wait_result(10, 10'h2A5);

        // Same task with ~50% gaps; no strobe gives a timeout.
        send_task(50);
        check_burst(-1);
        wait_result(-1, 10'h000);

        // Random task with gaps; strobe on the last WAIT cycle beats the timeout.
        fill_random();
        rdata = 10'($urandom_range(1023));
        send_task(50);
        check_burst(-1);
        wait_result(TMO - 1, rdata);

        // Reset at stream cycle 30: no result may ever appear for that task.
        fill_random();
        send_task(20);
        check_burst(30);
        any_res = 1'b0;
        repeat (80) begin
            @(negedge clk);
            any_res |= res_valid | snn_in_valid;
        end
        check("no_result_after_reset", any_res, 0);

        // A full task afterwards still runs cleanly.
        fill_random();
        rdata = 10'($urandom_range(1023));
        send_task(30);
        check_burst(-1);
        wait_result(20, rdata);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
